psram_arbiter: RTL and testbench
================================

PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, PSRAM byte-address width.
REQ-002 Parameter LEN_WIDTH, default 8, burst-length field width in bytes.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive port-A grants allowed while port B waits.
REQ-004 Port sysclk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port a_req / a_addr / a_len  input  1 / ADDR_WIDTH / LEN_WIDTH  display read request: flag, start address, byte count.
REQ-007 Port a_ack / a_byte / a_done  output  1 / 1 / 1  port A: request accepted, read byte valid, burst finished.
REQ-008 Port b_req / b_rw / b_addr / b_len / b_wdata  input  1 / 1 / ADDR_WIDTH / LEN_WIDTH / 8  MCU request; b_rw=1 write, 0 read.
REQ-009 Port b_ack / b_byte / b_done  output  1 / 1 / 1  port B handshake, same meaning as port A.
REQ-010 Port rdata  output  8  read byte, registered copy of psram_rdata, valid with a_byte or b_byte.
REQ-011 Port psram_start / psram_rw / psram_address / psram_len / psram_wdata  output  1 / 1 / ADDR_WIDTH / LEN_WIDTH / 8  command to PSRAM controller.
REQ-012 Port psram_byte / psram_rdata / psram_done  input  1 / 8 / 1  controller: byte transferred, read byte, burst complete.
REQ-013 Port error  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states: IDLE, ISSUE, XFER, FINISH; arbitration occurs only in IDLE.
REQ-015 In IDLE, a_req only -> grant A; b_req only -> grant B; both -> grant A unless REQ-027 forces B.
REQ-016 Grant at edge N: latch addr/len/rw of winner, pulse winner's ack and psram_start for exactly one cycle N+1, enter XFER.
REQ-017 Port A is read-only: psram_rw=0 on A grants.
REQ-018 psram_address/psram_len/psram_rw stay stable from psram_start until FSM leaves XFER.
REQ-019 psram_wdata = b_wdata combinationally while B-write granted, else 0; on each psram_byte the port presents the next byte by the following cycle.
REQ-020 Each psram_byte in XFER produces one-cycle byte pulse on granted port only, one cycle later, with rdata updated same cycle.
REQ-021 Internal byte counter (LEN_WIDTH bits) counts psram_byte; psram_done enters FINISH; FINISH pulses granted port's done one cycle, returns to IDLE.
REQ-022 psram_done with count != latched len, or psram_byte outside XFER, sets error; transfer still finishes normally.
REQ-023 len=0 request: ack then done on next cycle, no psram_start, counted as a grant.
REQ-024 req deasserted before ack: request withdrawn, no transfer; req held after done is a new request.
REQ-025 Minimum one IDLE cycle between consecutive bursts; back-to-back same-port requests permitted.

Reset
REQ-026 Reset asserted at any time (including mid-burst): FSM to IDLE, all outputs 0, counters 0, error cleared, latched command cleared, within the same cycle asynchronously; no done issued for aborted burst.

Configuration
REQ-027 Macro PSRAM_ARBITER_STARVATION_GUARD_EN defined: counter of consecutive A grants with b_req high; at STARVE_LIMIT next contested arbitration grants B and counter clears; B grant or b_req low clears it.
REQ-028 Macro undefined: strict fixed priority A over B, no counter logic.

Verification
REQ-029 a_req, a_addr=0x000100, a_len=4; controller returns 4 bytes 0x11..0x44 then done -> a_ack one cycle, psram_start with addr 0x000100 len 4 rw 0, four a_byte with rdata 0x11..0x44, one a_done, b_* all 0.
REQ-030 b_req, b_rw=1, b_addr=0x7FFFFF, b_len=2, b_wdata 0xA5 then 0x5A -> psram_rw=1, psram_wdata 0xA5 then 0x5A per psram_byte, b_done once.
REQ-031 a_req and b_req held continuously, len=1 each, guard enabled -> grant order A,A,A,A,B,A...; guard disabled -> B never granted while a_req high.
REQ-032 psram_done after 2 bytes of len=3 burst -> error=1 and stays 1, granted done still pulses, next request serviced normally.
REQ-033 reset pulsed after 1 byte of len=8 burst -> all outputs 0 immediately, no done, next a_req granted cleanly.

Source files
------------

// File: rtl/psram_arbiter.sv
// psram_arbiter
// -----------------------------------------------------------------------------
// Two-port arbiter in front of a byte-oriented PSRAM controller.
//   Port A : display refresh path, read-only burst requests.
//   Port B : MCU path, read or write burst requests (b_rw=1 write).
// Only one burst is in flight at a time. Arbitration happens only in IDLE.
// By default A always wins a contested arbitration. When the macro
// PSRAM_ARBITER_STARVATION_GUARD_EN is defined, B is granted after
// STARVE_LIMIT consecutive A grants that were made while b_req was high.
//
// Handshake (both ports):
//   The requester raises *_req with addr/len (and rw/wdata for B) stable and
//   keeps them until it sees *_ack. If *_req drops before the arbiter samples
//   it in IDLE, the request is simply withdrawn. *_ack pulses one cycle after
//   the grant edge; from then on, *_byte pulses once per transferred byte
//   (rdata valid with it on reads; for B writes the requester presents the
//   next b_wdata by the cycle after each transfer) and *_done pulses once
//   when the burst is over. A req still high after done is a new request.
//
// Ports:
//   sysclk, reset                         clock, async active-high reset
//   a_req/a_addr/a_len                    port A request
//   a_ack/a_byte/a_done                   port A status pulses
//   b_req/b_rw/b_addr/b_len/b_wdata       port B request
//   b_ack/b_byte/b_done                   port B status pulses
//   rdata                                 registered read byte
//   psram_start/rw/address/len/wdata      command to PSRAM controller
//   psram_byte/psram_rdata/psram_done     controller status
//   error                                 sticky protocol-error flag
//   state_dbg                             current FSM state (debug)
// -----------------------------------------------------------------------------
module psram_arbiter #(
  parameter int ADDR_WIDTH   = 23,
  parameter int LEN_WIDTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  sysclk,
  input  logic                  reset,
  // port A
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [LEN_WIDTH-1:0]  a_len,
  output logic                  a_ack,
  output logic                  a_byte,
  output logic                  a_done,
  // port B
  input  logic                  b_req,
  input  logic                  b_rw,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [LEN_WIDTH-1:0]  b_len,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic                  b_byte,
  output logic                  b_done,
  // shared read data
  output logic [7:0]            rdata,
  // PSRAM controller command
  output logic                  psram_start,
  output logic                  psram_rw,
  output logic [ADDR_WIDTH-1:0] psram_address,
  output logic [LEN_WIDTH-1:0]  psram_len,
  output logic [7:0]            psram_wdata,
  // PSRAM controller status
  input  logic                  psram_byte,
  input  logic [7:0]            psram_rdata,
  input  logic                  psram_done,
  // status / debug
  output logic                  error,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Latched command of the granted port.
  logic                  cmd_b;
  logic                  cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic [LEN_WIDTH-1:0]  byte_cnt;
  logic                  byte_q;
  logic                  error_q;

  logic                  grant_a;
  logic                  grant_b;
  logic                  grant;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef PSRAM_ARBITER_STARVATION_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));
  // A keeps priority unless B has already waited through STARVE_LIMIT A grants.
  assign grant_a    = a_req && !(b_req && starve_hit);

  // Counts consecutive A grants taken while B was waiting. Any cycle with
  // b_req low means B is not starving, so the history is discarded.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!b_req) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_b) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`else
  assign grant_a = a_req;
`endif

  assign grant_b = b_req && !grant_a;
  assign grant   = (state == ST_IDLE) && (grant_a || grant_b);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    a_done      = 1'b0;
    b_done      = 1'b0;
    psram_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_a || grant_b) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        a_ack       = !cmd_b;
        b_ack       = cmd_b;
        // A zero-length request is acknowledged and finished without ever
        // bothering the controller.
        psram_start = (cmd_len != '0);
        state_next  = (cmd_len == '0) ? ST_FINISH : ST_XFER;
      end
      ST_XFER: begin
        if (psram_done) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        a_done     = !cmd_b;
        b_done     = cmd_b;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched command, byte counter, read data, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cmd_b    <= 1'b0;
      cmd_rw   <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      byte_cnt <= '0;
      byte_q   <= 1'b0;
      rdata    <= 8'h00;
      error_q  <= 1'b0;
    end else begin
      byte_q <= psram_byte && (state == ST_XFER);

      if (grant) begin
        cmd_b    <= grant_b;
        // Port A is read-only, so rw is forced low on A grants.
        cmd_rw   <= grant_b && b_rw;
        cmd_addr <= grant_b ? b_addr : a_addr;
        cmd_len  <= grant_b ? b_len : a_len;
        byte_cnt <= '0;
      end

      if ((state == ST_XFER) && psram_byte) begin
        byte_cnt <= byte_cnt + LEN_WIDTH'(1);
        rdata    <= psram_rdata;
      end

      // A byte strobe with no burst running is a controller protocol fault.
      if (psram_byte && (state != ST_XFER)) begin
        error_q <= 1'b1;
      end

      // Short or long bursts are flagged but still finished normally. The
      // byte arriving in the same cycle as done is included in the count.
      if ((state == ST_XFER) && psram_done &&
          ((byte_cnt + LEN_WIDTH'(psram_byte)) != cmd_len)) begin
        error_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a_byte        = byte_q && !cmd_b;
  assign b_byte        = byte_q && cmd_b;

  // Command fields come straight from the latch, so they hold from
  // psram_start until the next grant.
  assign psram_rw      = cmd_rw;
  assign psram_address = cmd_addr;
  assign psram_len     = cmd_len;

  assign psram_wdata   = ((state != ST_IDLE) && cmd_b && cmd_rw) ? b_wdata : 8'h00;

  assign error         = error_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter
// Directed bench for psram_arbiter. Each driven cycle pushes the outputs the
// arbiter must show in that cycle into exp_q; a single compare process pops
// and checks them on the falling edge.
module tb_psram_arbiter;

  localparam int AW = 23;
  localparam int LW = 8;
  localparam int EW = 2 + 8 + 8 + 8 + 1 + AW + LW;

`ifdef PSRAM_ARBITER_STARVATION_GUARD_EN
  localparam logic [5:0] EXP_SEQ = 6'b000010;  // A,A,A,A,B,A
`else
  localparam logic [5:0] EXP_SEQ = 6'b000000;  // A only
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          sysclk = 1'b0;
  logic          reset  = 1'b1;
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic [LW-1:0] a_len;
  logic          a_ack, a_byte, a_done;
  logic          b_req, b_rw;
  logic [AW-1:0] b_addr;
  logic [LW-1:0] b_len;
  logic [7:0]    b_wdata;
  logic          b_ack, b_byte, b_done;
  logic [7:0]    rdata;
  logic          psram_start, psram_rw;
  logic [AW-1:0] psram_address;
  logic [LW-1:0] psram_len;
  logic [7:0]    psram_wdata;
  logic          psram_byte;
  logic [7:0]    psram_rdata;
  logic          psram_done;
  logic          error;
  logic [1:0]    state_dbg;

  always #5 sysclk = ~sysclk;

  psram_arbiter #(
    .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW),
    .STARVE_LIMIT(4)
  ) dut (
    .sysclk(sysclk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_len(a_len),
    .a_ack(a_ack), .a_byte(a_byte), .a_done(a_done),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_byte(b_byte), .b_done(b_done),
    .rdata(rdata),
    .psram_start(psram_start), .psram_rw(psram_rw), .psram_address(psram_address),
    .psram_len(psram_len), .psram_wdata(psram_wdata),
    .psram_byte(psram_byte), .psram_rdata(psram_rdata), .psram_done(psram_done),
    .error(error), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and model
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            exp_err = 1'b0;   // expected sticky error level
  int            a_streak = 0;     // A grants in a row while B waited
  bit            last_ack_b = 1'b0;
  logic [7:0]    rd_data[16];
  logic [7:0]    wr_data[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // flags = {a_ack,a_byte,a_done,b_ack,b_byte,b_done,psram_start,error}
  function automatic logic [7:0] flags(input bit aa, input bit ab, input bit ad,
                                       input bit ba, input bit bb, input bit bd,
                                       input bit st);
    return {aa, ab, ad, ba, bb, bd, st, exp_err};
  endfunction

  task automatic push_exp(input logic [7:0] fl, input bit crd, input logic [7:0] rd,
                          input logic [7:0] wd, input bit ccmd, input logic rw,
                          input logic [AW-1:0] ad, input logic [LW-1:0] ln);
    exp_q.push_back({ccmd, crd, fl, rd, wd, rw, ad, ln});
  endtask

  // Winner of an arbitration in IDLE, from the priority rules.
  function automatic bit model_pick_b(input bit ra, input bit rb);
    bit wb;
    if (ra && rb) begin
`ifdef PSRAM_ARBITER_STARVATION_GUARD_EN
      wb = (a_streak >= 4);
`else
      wb = 1'b0;
`endif
    end else begin
      wb = rb;
    end
    return wb;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge sysclk) begin
    logic [EW-1:0] e;
    logic          e_cmd, e_crd, e_rw;
    logic [7:0]    e_fl, e_rd, e_wd;
    logic [AW-1:0] e_ad;
    logic [LW-1:0] e_ln;
    if (a_ack || b_ack) last_ack_b = b_ack;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {e_cmd, e_crd, e_fl, e_rd, e_wd, e_rw, e_ad, e_ln} = e;
      chk("flags", {24'h0, a_ack, a_byte, a_done, b_ack, b_byte, b_done, psram_start, error},
          {24'h0, e_fl});
      chk("psram_wdata", {24'h0, psram_wdata}, {24'h0, e_wd});
      if (e_crd) chk("rdata", {24'h0, rdata}, {24'h0, e_rd});
      if (e_cmd) chk("cmd_rw_addr_len", {psram_rw, psram_address, psram_len}, {e_rw, e_ad, e_ln});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_cycle();
    push_exp(flags(0, 0, 0, 0, 0, 0, 0), 0, 8'h00, 8'h00, 0, 0, '0, '0);
    tick();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_flags"}, {23'h0, a_ack, a_byte, a_done, b_ack, b_byte, b_done, psram_start,
        psram_rw, error}, 32'h0);
    chk({nm, "_rdata"}, {24'h0, rdata}, 32'h0);
    chk({nm, "_addr"}, {9'h0, psram_address}, 32'h0);
    chk({nm, "_len"}, {24'h0, psram_len}, 32'h0);
    chk({nm, "_wdata"}, {24'h0, psram_wdata}, 32'h0);
  endtask

  // One complete burst from an IDLE cycle. Requests for the ports in ra/rb
  // are raised; the controller returns nbytes bytes back to back and then
  // done. keep=1 leaves both requests high throughout.
  task automatic burst(input bit ra, input bit rb, input int nbytes, input bit keep);
    bit            wb, rw, wr;
    logic [AW-1:0] ad;
    logic [LW-1:0] ln;
    logic [7:0]    last_rd;
    wb = model_pick_b(ra, rb);
    if (wb || !rb) a_streak = 0;
    else a_streak = a_streak + 1;
    ad = wb ? b_addr : a_addr;
    ln = wb ? b_len : a_len;
    rw = wb ? b_rw : 1'b0;
    wr = wb && rw;
    // IDLE cycle: arbitration edge at its end
    a_req = ra;
    b_req = rb;
    if (wr) b_wdata = wr_data[0];
    push_exp(flags(0, 0, 0, 0, 0, 0, 0), 0, 8'h00, 8'h00, 0, 0, '0, '0);
    tick();
    // ack / start cycle
    if (!keep) begin
      a_req = 1'b0;
      b_req = 1'b0;
    end
    push_exp(flags(!wb, 0, 0, wb, 0, 0, ln != '0), 0, 8'h00, wr ? b_wdata : 8'h00,
             1, rw, ad, ln);
    tick();
    if (ln != '0) begin
      for (int k = 0; k < nbytes; k++) begin
        psram_byte  = 1'b1;
        psram_rdata = rd_data[k];
        if (wr) b_wdata = wr_data[k];
        last_rd = (k > 0) ? rd_data[k-1] : 8'h00;
        push_exp(flags(0, !wb && k > 0, 0, 0, wb && k > 0, 0, 0), k > 0, last_rd,
                 wr ? b_wdata : 8'h00, 0, 0, '0, '0);
        tick();
      end
      psram_byte  = 1'b0;
      psram_rdata = 8'h00;
      psram_done  = 1'b1;
      last_rd = (nbytes > 0) ? rd_data[nbytes-1] : 8'h00;
      push_exp(flags(0, !wb && nbytes > 0, 0, 0, wb && nbytes > 0, 0, 0), nbytes > 0,
               last_rd, wr ? b_wdata : 8'h00, 0, 0, '0, '0);
      tick();
      psram_done = 1'b0;
      if (nbytes != int'(ln)) exp_err = 1'b1;
    end
    // done cycle
    push_exp(flags(0, 0, !wb, 0, 0, wb, 0), 0, 8'h00, wr ? b_wdata : 8'h00, 0, 0, '0, '0);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] seq;
    a_req = 0; a_addr = '0; a_len = '0;
    b_req = 0; b_rw = 0; b_addr = '0; b_len = '0; b_wdata = 8'h00;
    psram_byte = 0; psram_rdata = 8'h00; psram_done = 0;
    for (int i = 0; i < 16; i++) begin
      rd_data[i] = 8'h00;
      wr_data[i] = 8'h00;
    end

    repeat (2) @(posedge sysclk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Display read, 4 bytes
    a_addr = 23'h000100; a_len = 8'd4;
    rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
    burst(1, 0, 4, 0);
    chk("rdata_last_lit", {24'h0, rdata}, 32'h44);
    idle_cycle();

    // MCU write to the top address, 2 bytes
    b_rw = 1'b1; b_addr = 23'h7FFFFF; b_len = 8'd2;
    wr_data[0] = 8'hA5; wr_data[1] = 8'h5A;
    rd_data[0] = 8'h01; rd_data[1] = 8'h02;
    burst(0, 1, 2, 0);
    idle_cycle();        // b_wdata still 0x5A: wdata must be gated off
    b_wdata = 8'h00;

    // Zero-length MCU read: ack then done, no start
    b_rw = 1'b0; b_addr = 23'h000ABC; b_len = 8'd0;
    burst(0, 1, 0, 0);

    // Back-to-back single-byte display read
    a_addr = 23'h000010; a_len = 8'd1; rd_data[0] = 8'hC3;
    burst(1, 0, 1, 0);

    // Early done: 2 bytes of a 3-byte burst
    a_addr = 23'h000020; a_len = 8'd3; rd_data[0] = 8'h5E; rd_data[1] = 8'h6F;
    burst(1, 0, 2, 0);
    chk("error_set_lit", {31'h0, error}, 32'h1);
    idle_cycle();
    idle_cycle();
    chk("error_sticky_lit", {31'h0, error}, 32'h1);

    // Next request after the error is serviced normally
    a_addr = 23'h000030; a_len = 8'd2; rd_data[0] = 8'hD1; rd_data[1] = 8'hD2;
    burst(1, 0, 2, 0);

    // Both ports requesting continuously, len 1 each
    a_addr = 23'h000040; a_len = 8'd1;
    b_addr = 23'h000050; b_len = 8'd1; b_rw = 1'b0;
    rd_data[0] = 8'h77;
    seq = 6'b0;
    for (int i = 0; i < 6; i++) begin
      burst(1, 1, 1, i < 5);
      seq = {seq[4:0], last_ack_b};
    end
    chk("grant_order_lit", {26'h0, seq}, {26'h0, EXP_SEQ});

    // Reset in the middle of an 8-byte burst
    a_addr = 23'h000200; a_len = 8'd8; a_req = 1'b1;
    push_exp(flags(0, 0, 0, 0, 0, 0, 0), 0, 8'h00, 8'h00, 0, 0, '0, '0);
    tick();
    a_req = 1'b0;
    push_exp(flags(1, 0, 0, 0, 0, 0, 1), 0, 8'h00, 8'h00, 1, 0, 23'h000200, 8'd8);
    tick();
    psram_byte = 1'b1; psram_rdata = 8'h99;
    push_exp(flags(0, 0, 0, 0, 0, 0, 0), 0, 8'h00, 8'h00, 0, 0, '0, '0);
    tick();
    psram_byte = 1'b0; psram_rdata = 8'h00;
    push_exp(flags(0, 1, 0, 0, 0, 0, 0), 1, 8'h99, 8'h00, 0, 0, '0, '0);
    #6;
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(posedge sysclk);
    #1;
    check_all_zero("reset_hold");
    reset = 1'b0;
    exp_err = 1'b0;
    a_streak = 0;
    idle_cycle();
    idle_cycle();
    idle_cycle();

    // Clean grant after the aborted burst
    a_addr = 23'h000300; a_len = 8'd2; rd_data[0] = 8'hE1; rd_data[1] = 8'hE2;
    burst(1, 0, 2, 0);
    idle_cycle();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
